pipe_stage_rv: RTL and testbench
================================

Name: pipe_stage_rv

Overview:
- Parametrised elastic pipeline register chain for the RISC-V core. It is the next generation of the fixed stage registers.
- Carries a packed payload of DATA_W bits through DEPTH register slices.
- Uses a valid/ready handshake with per-slice valid bits and bubble collapsing.
- Also supports a global flush and a stall freeze, plus an occupancy count.
- Sits between pipeline stages, for example decode→execute, with the control and data buses packed into one payload by the instantiating stage.

Parameters:
- DATA_W, 32, payload width in bits (1..256).
- DEPTH, 1, number of register slices (1..8).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- flush  input  1  kill all in-flight entries at the next edge.
- stall  input  1  freeze all slices; no transfers on either side.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  last slice holds a valid payload.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  DATA_W  payload of last slice; 0 whenever out_valid=0.
- count  output  $clog2(DEPTH+2)  number of valid entries held.

Behaviour:
- Reset, clock and handshake:
  - One clock domain. rst is sampled on the clk rising edge only; it is synchronous and active-high.
  - While rst=1 and on the edge it is sampled, all valid bits and all data registers clear to 0.
  - Reset outputs: out_valid=0, out_data=0, count=0, in_ready=0 while rst=1. in_ready=1 on the first cycle after rst deasserts.
  - Transfers: in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- Slice i, where slice 0 is the input side:
  - Holds vld[i] and dat[i].
  - rdy[DEPTH] = out_ready.
  - rdy[i] = !vld[i] | rdy[i+1]. This is a combinational ready chain that collapses bubbles.
  - When rdy[i] is true, the slice loads: vld[i] <= vld[i-1], dat[i] <= dat[i-1]. For slice 0 the source is in_valid and in_data.
  - If the source is invalid, vld[i] clears and dat[i] holds; it is a don't-care.
- Latency and throughput:
  - Latency is DEPTH cycles from in_fire to out_valid with no backpressure.
  - Throughput is 1 transfer per cycle.
  - in_ready = rdy[0] & !stall & !flush & !rst.
  - out_valid = vld[DEPTH-1] & !stall & !flush.
- Priority: rst > flush > stall > normal advance.
- Flush:
  - The edge clears every vld and zeros every dat.
  - During the flush cycle in_ready=0 and out_valid=0, so no fire occurs on either side.
  - Flush takes priority over stall.
- Stall:
  - No register changes.
  - in_ready=0 and out_valid=0 (masked). Held state is re-presented when stall drops.
- Backpressure:
  - With out_ready=0 the chain fills from the output end.
  - Once full (count=DEPTH), in_ready=0.
  - When out_ready=1 and the chain is full, in_ready=1 in the same cycle. This gives a simultaneous in_fire and out_fire with count unchanged.
- count:
  - count = popcount of vld plus any optional skid entry.
  - It updates on the edge: +1 on in_fire only, −1 on out_fire only, unchanged on both or neither.
  - It goes to 0 on flush or rst.
- Payload ordering is strictly FIFO. There is no drop and no duplication.
- Protocol:
  - in_data and in_valid must hold while in_valid=1 and in_ready=0.
  - out_data is stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: PIPE_STAGE_RV_SKID_EN.
- When defined:
  - A one-entry skid buffer is placed in front of slice 0.
  - in_ready becomes a registered signal: in_ready = !skid_vld & !stall & !flush & !rst.
  - If in_fire occurs while rdy[0]=0, the payload is captured in the skid buffer.
  - The skid buffer drains into slice 0 with priority over new input.
  - The skid buffer is bypassed when empty, so latency is unchanged.
  - Capacity becomes DEPTH+1 and count max is DEPTH+1.
  - flush and rst clear the skid buffer.
- When undefined: combinational in_ready as above; capacity is DEPTH.

Test Plan:
- Streaming: DEPTH=3, out_ready=1, send 0x11,0x22,0x33 on consecutive cycles → out_valid rises 3 cycles after the first fire, outputs 0x11,0x22,0x33 on consecutive cycles, count peaks at 3.
- Backpressure: DEPTH=2, out_ready=0, offer 0xA,0xB,0xC → 0xA,0xB accepted, in_ready=0 for 0xC, count=2. Raise out_ready → 0xA out and 0xC accepted in the same cycle, count stays 2.
- Flush mid-stream: 2 entries held, assert flush with in_valid=1 → in_ready=0 that cycle, next cycle count=0, out_valid=0, out_data=0, no stale entry is ever emitted.
- Stall: 1 entry held (0x55), stall=1 for 4 cycles with out_ready=1 → out_valid=0 and in_ready=0 throughout. After stall drops, 0x55 is delivered once.
- Reset mid-operation: full chain, assert rst one cycle → all outputs 0, in_ready=0 during rst, in_ready=1 and count=0 the cycle after.
- Skid (PIPE_STAGE_RV_SKID_EN, DEPTH=1): out_ready=0, two fires → second lands in skid, count=2, in_ready registered low. Drain with out_ready=1 → order preserved.

Source files
------------

// File: rtl/pipe_stage_rv.sv
// pipe_stage_rv: elastic valid/ready register chain of DEPTH slices carrying a
// DATA_W-bit payload. The combinational ready chain lets a bubble anywhere in
// the chain be filled, even while the output is back-pressured. The chain also
// provides a global flush, a stall freeze and an occupancy count.
//
// Optional build macro PIPE_STAGE_RV_SKID_EN adds a one-entry skid buffer in
// front of slice 0. With the skid buffer, in_ready depends only on registered
// state plus the stall/flush/rst controls, and total capacity becomes DEPTH+1.
module pipe_stage_rv #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       stall,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+2)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 2);

    // Slice state; slice 0 is on the input side, slice DEPTH-1 drives the output.
    logic [DEPTH-1:0]  vld_q;
    logic [DEPTH-1:0]  vld_d;
    logic [DATA_W-1:0] dat_q [DEPTH];
    logic [DATA_W-1:0] dat_d [DEPTH];
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;

    // rdy[i]: slice i may load this cycle (it is empty or its content moves on).
    logic [DEPTH-1:0]  rdy;
    logic              in_fire;
    logic              out_fire;

    // Source feeding slice 0: either the skid entry or the input port.
    logic              src_vld;
    logic [DATA_W-1:0] src_dat;

`ifdef PIPE_STAGE_RV_SKID_EN
    logic              skid_vld_q;
    logic              skid_vld_d;
    logic [DATA_W-1:0] skid_dat_q;
    logic [DATA_W-1:0] skid_dat_d;
`endif

    // Ready chain: a slice is ready if any slice at or after it is empty, or
    // the downstream consumer takes the last slice. The bubble flag is
    // accumulated in a local variable so that no signal feeds back on itself.
    always_comb begin
        logic bubble;
        bubble = 1'b0;
        rdy    = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            bubble = bubble | ~vld_q[i];
            rdy[i] = bubble | out_ready;
        end
    end

    // Handshake outputs. Stall, flush and reset mask both sides so that no
    // transfer can happen while the chain is frozen or being cleared.
    always_comb begin
`ifdef PIPE_STAGE_RV_SKID_EN
        in_ready  = ~skid_vld_q & ~stall & ~flush & ~rst;
`else
        in_ready  = rdy[0] & ~stall & ~flush & ~rst;
`endif
        out_valid = vld_q[DEPTH-1] & ~stall & ~flush & ~rst;
        out_data  = out_valid ? dat_q[DEPTH-1] : '0;
        in_fire   = in_valid & in_ready;
        out_fire  = out_valid & out_ready;
        count     = rst ? '0 : count_q;
    end

    // Slice 0 source select: a waiting skid entry has priority over new input,
    // which keeps the payload order strictly FIFO.
    always_comb begin
`ifdef PIPE_STAGE_RV_SKID_EN
        src_vld = skid_vld_q | in_fire;
        src_dat = skid_vld_q ? skid_dat_q : in_data;
`else
        src_vld = in_fire;
        src_dat = in_data;
`endif
    end

    // Chain next state: flush zeroes everything, stall holds everything,
    // otherwise each ready slice takes its upstream neighbour. An invalid
    // source clears the valid bit and leaves the data register untouched.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (flush) begin
            vld_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat_d[i] = '0;
            end
        end else if (!stall) begin
            if (rdy[0]) begin
                vld_d[0] = src_vld;
                if (src_vld) begin
                    dat_d[0] = src_dat;
                end
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    vld_d[i] = vld_q[i-1];
                    if (vld_q[i-1]) begin
                        dat_d[i] = dat_q[i-1];
                    end
                end
            end
        end
    end

    // Occupancy: +1 on an input transfer, -1 on an output transfer, and
    // unchanged when both or neither occur. Both fires are already masked
    // by stall and flush.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            case ({in_fire, out_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

`ifdef PIPE_STAGE_RV_SKID_EN
    // Skid next state: capture an accepted payload that slice 0 cannot take,
    // and release the entry once slice 0 loads from it.
    always_comb begin
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        if (flush) begin
            skid_vld_d = 1'b0;
            skid_dat_d = '0;
        end else if (!stall) begin
            if (skid_vld_q && rdy[0]) begin
                skid_vld_d = 1'b0;
            end else if (in_fire && !rdy[0]) begin
                skid_vld_d = 1'b1;
                skid_dat_d = in_data;
            end
        end
    end

    // Skid register; reset clears both the flag and the held payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
        end else begin
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
        end
    end
`endif

    // Slice and count registers; reset clears valid bits, data and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_rv.sv
// Testbench for pipe_stage_rv. There are three instances with DATA_W=8: DEPTH=3,
// DEPTH=2 and DEPTH=1. Each vector row drives one instance for one cycle.
// The idle instances see in_valid=0. Outputs are sampled 1ns after the falling
// edge, before the next rising edge. When PIPE_STAGE_RV_SKID_EN is defined,
// only the skid table on the DEPTH=1 instance is run.
module tb_pipe_stage_rv;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DEPTH=3 instance signals
    logic       d3_fl, d3_st, d3_iv, d3_irdy, d3_ov, d3_ordy;
    logic [7:0] d3_id, d3_od;
    logic [2:0] d3_cnt;
    // DEPTH=2 instance signals
    logic       d2_fl, d2_st, d2_iv, d2_irdy, d2_ov, d2_ordy;
    logic [7:0] d2_id, d2_od;
    logic [1:0] d2_cnt;
    // DEPTH=1 instance signals
    logic       d1_fl, d1_st, d1_iv, d1_irdy, d1_ov, d1_ordy;
    logic [7:0] d1_id, d1_od;
    logic [1:0] d1_cnt;

    pipe_stage_rv #(.DATA_W(8), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .flush(d3_fl), .stall(d3_st),
        .in_valid(d3_iv), .in_ready(d3_irdy), .in_data(d3_id),
        .out_valid(d3_ov), .out_ready(d3_ordy), .out_data(d3_od), .count(d3_cnt)
    );
    pipe_stage_rv #(.DATA_W(8), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .flush(d2_fl), .stall(d2_st),
        .in_valid(d2_iv), .in_ready(d2_irdy), .in_data(d2_id),
        .out_valid(d2_ov), .out_ready(d2_ordy), .out_data(d2_od), .count(d2_cnt)
    );
    pipe_stage_rv #(.DATA_W(8), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .flush(d1_fl), .stall(d1_st),
        .in_valid(d1_iv), .in_ready(d1_irdy), .in_data(d1_id),
        .out_valid(d1_ov), .out_ready(d1_ordy), .out_data(d1_od), .count(d1_cnt)
    );

    typedef struct {
        int         dut;     // 0: DEPTH=3, 1: DEPTH=2, 2: DEPTH=1
        logic       rst;
        logic       flush;
        logic       stall;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       e_irdy;
        logic       e_ov;
        logic [7:0] e_od;
        int         e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(int dut, logic r, logic fl, logic st, logic iv,
                                logic [7:0] id, logic ordy, logic e_irdy,
                                logic e_ov, logic [7:0] e_od, int e_cnt);
        vec_t v;
        v.dut = dut; v.rst = r; v.flush = fl; v.stall = st; v.iv = iv;
        v.id = id; v.ordy = ordy; v.e_irdy = e_irdy; v.e_ov = e_ov;
        v.e_od = e_od; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", nm, idx, act, exp_v);
        end
    endtask

    task automatic idle_all();
        d3_fl = 0; d3_st = 0; d3_iv = 0; d3_id = 0; d3_ordy = 0;
        d2_fl = 0; d2_st = 0; d2_iv = 0; d2_id = 0; d2_ordy = 0;
        d1_fl = 0; d1_st = 0; d1_iv = 0; d1_id = 0; d1_ordy = 0;
    endtask

    task automatic drive(input vec_t v);
        idle_all();
        rst = v.rst;
        case (v.dut)
            0: begin d3_fl = v.flush; d3_st = v.stall; d3_iv = v.iv; d3_id = v.id; d3_ordy = v.ordy; end
            1: begin d2_fl = v.flush; d2_st = v.stall; d2_iv = v.iv; d2_id = v.id; d2_ordy = v.ordy; end
            default: begin d1_fl = v.flush; d1_st = v.stall; d1_iv = v.iv; d1_id = v.id; d1_ordy = v.ordy; end
        endcase
    endtask

    task automatic check_vec(input vec_t v, input int idx);
        logic       a_irdy, a_ov;
        logic [7:0] a_od;
        int         a_cnt;
        case (v.dut)
            0: begin a_irdy = d3_irdy; a_ov = d3_ov; a_od = d3_od; a_cnt = int'(d3_cnt); end
            1: begin a_irdy = d2_irdy; a_ov = d2_ov; a_od = d2_od; a_cnt = int'(d2_cnt); end
            default: begin a_irdy = d1_irdy; a_ov = d1_ov; a_od = d1_od; a_cnt = int'(d1_cnt); end
        endcase
        chk("in_ready", idx, 32'(a_irdy), 32'(v.e_irdy));
        chk("out_valid", idx, 32'(a_ov), 32'(v.e_ov));
        chk("out_data", idx, 32'(a_od), 32'(v.e_od));
        chk("count", idx, 32'(a_cnt), 32'(v.e_cnt));
    endtask

    // Watchdog: the bench must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] got[$];
        logic [7:0] exp_q[$];

        rst = 1'b1;
        idle_all();

`ifndef PIPE_STAGE_RV_SKID_EN
        //             dut rst fl st iv id     ordy | irdy ov od     cnt
        // Reset state on both instances
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0,   0,  0, 8'h00, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 8'h00, 0,   0,  0, 8'h00, 0));
        // Streaming through DEPTH=3
        vecs.push_back(mk(0, 0, 0, 0, 1, 8'h11, 1,   1,  0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 8'h22, 1,   1,  0, 8'h00, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 8'h33, 1,   1,  0, 8'h00, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 1,   1,  1, 8'h11, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 1,   1,  1, 8'h22, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 1,   1,  1, 8'h33, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 1,   1,  0, 8'h00, 0));
        // Stall with 0x55 sitting in the last slice of DEPTH=3
        vecs.push_back(mk(0, 0, 0, 0, 1, 8'h55, 0,   1,  0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0,   1,  0, 8'h00, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0,   1,  0, 8'h00, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 1,   0,  0, 8'h00, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 1,   0,  0, 8'h00, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 1,   0,  0, 8'h00, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 1,   0,  0, 8'h00, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 1,   1,  1, 8'h55, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 1,   1,  0, 8'h00, 0));
        // Backpressure on DEPTH=2
        vecs.push_back(mk(1, 0, 0, 0, 1, 8'h0A, 0,   1,  0, 8'h00, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 8'h0B, 0,   1,  0, 8'h00, 1));
        vecs.push_back(mk(1, 0, 0, 0, 1, 8'h0C, 0,   0,  1, 8'h0A, 2));
        vecs.push_back(mk(1, 0, 0, 0, 1, 8'h0C, 1,   1,  1, 8'h0A, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 1,   1,  1, 8'h0B, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 1,   1,  1, 8'h0C, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 1,   1,  0, 8'h00, 0));
        // Flush mid-stream with two entries held
        vecs.push_back(mk(1, 0, 0, 0, 1, 8'h71, 0,   1,  0, 8'h00, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 8'h72, 0,   1,  0, 8'h00, 1));
        vecs.push_back(mk(1, 0, 1, 0, 1, 8'h73, 1,   0,  0, 8'h00, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 1,   1,  0, 8'h00, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 1,   1,  0, 8'h00, 0));
        // Flush wins over a simultaneous stall
        vecs.push_back(mk(1, 0, 0, 0, 1, 8'h74, 0,   1,  0, 8'h00, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 8'h00, 0,   0,  0, 8'h00, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 1,   1,  0, 8'h00, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 1,   1,  0, 8'h00, 0));
        // Reset with a full DEPTH=2 chain
        vecs.push_back(mk(1, 0, 0, 0, 1, 8'h81, 0,   1,  0, 8'h00, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 8'h82, 0,   1,  0, 8'h00, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0,   0,  1, 8'h81, 2));
        vecs.push_back(mk(1, 1, 0, 0, 0, 8'h00, 0,   0,  0, 8'h00, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 1,   1,  0, 8'h00, 0));
`else
        // Skid buffer on DEPTH=1
        vecs.push_back(mk(2, 1, 0, 0, 0, 8'h00, 0,   0,  0, 8'h00, 0));
        vecs.push_back(mk(2, 0, 0, 0, 1, 8'h91, 0,   1,  0, 8'h00, 0));
        vecs.push_back(mk(2, 0, 0, 0, 1, 8'h92, 0,   1,  1, 8'h91, 1));
        vecs.push_back(mk(2, 0, 0, 0, 1, 8'h93, 0,   0,  1, 8'h91, 2));
        vecs.push_back(mk(2, 0, 0, 0, 1, 8'h93, 1,   0,  1, 8'h91, 2));
        vecs.push_back(mk(2, 0, 0, 0, 1, 8'h93, 1,   1,  1, 8'h92, 1));
        vecs.push_back(mk(2, 0, 0, 0, 0, 8'h00, 1,   1,  1, 8'h93, 1));
        vecs.push_back(mk(2, 0, 0, 0, 0, 8'h00, 1,   1,  0, 8'h00, 0));
`endif

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check_vec(vecs[i], i);
        end

`ifndef PIPE_STAGE_RV_SKID_EN
        // Fill DEPTH=3 under backpressure, then release with a simultaneous
        // in/out transfer and drain, checking FIFO order.
        @(negedge clk);
        idle_all();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            d3_iv = 1'b1;
            d3_id = 8'(8'hA1 + k);
            #1;
            chk("fill_in_ready", k, 32'(d3_irdy), 32'd1);
        end
        @(negedge clk);
        d3_id = 8'hA4;
        #1;
        chk("full_in_ready", 0, 32'(d3_irdy), 32'd0);
        chk("full_count", 0, 32'(d3_cnt), 32'd3);
        chk("full_out_data", 0, 32'(d3_od), 32'h0A1);
        @(negedge clk);
        d3_ordy = 1'b1;
        #1;
        chk("release_in_ready", 0, 32'(d3_irdy), 32'd1);
        chk("release_count", 0, 32'(d3_cnt), 32'd3);
        @(negedge clk);
        d3_iv = 1'b0;
        d3_id = 8'h00;
        exp_q = '{8'hA2, 8'hA3, 8'hA4};
        for (int c = 0; c < 20 && got.size() < 3; c++) begin
            #1;
            if (d3_ov) got.push_back(d3_od);
            @(negedge clk);
        end
        chk("drain_len", 0, 32'(got.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < got.size()) chk("drain_order", k, 32'(got[k]), 32'(exp_q[k]));
        end
        #1;
        chk("drain_count", 0, 32'(d3_cnt), 32'd0);
        chk("drain_out_valid", 0, 32'(d3_ov), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
